vga_sprite_update_scheduler: RTL and testbench
==============================================

// Module: vga_sprite_update_scheduler
// PURPOSE
//   Frame-synchronous position scheduler for the VGA sprite overlay. Game logic posts sprite
//   position updates (player0, player1, powerup0) at any time through a valid/ready port; the
//   block stages them in shadow registers and commits them to the live position outputs only at
//   the start of vertical sync. The overlay compare logic therefore never sees a mid-frame
//   change, which prevents tearing. Sits between the game datapath and vga_controller.
// PARAMETERS
//   NUM_SPRITES  3    number of sprite slots (id 0=player0, 1=player1, 2=powerup0)
//   X_MAX        640  visible width in pixels
//   Y_MAX        480  visible height in lines
//   SPRITE_W     32   sprite width and height; positions clamp so the sprite stays on screen
// PORTS
//   iVGA_CLK     in   1     pixel clock; all logic on posedge
//   iRST_n       in   1     synchronous active-low reset
//   iVS          in   1     vsync from video_sync_generator, active-low
//   req_valid    in   1     update request valid
//   req_ready    out  1     block can accept a request this cycle
//   req_id       in   2     target sprite slot
//   req_x        in   32    requested x (unsigned; bits above [9:0] honoured for clamping)
//   req_y        in   32    requested y (unsigned; bits above [8:0] honoured for clamping)
//   sprite_x     out  10*NUM_SPRITES  live x per slot, slot i at [10*i+9:10*i]
//   sprite_y     out  9*NUM_SPRITES   live y per slot, slot i at [9*i+8:9*i]
//   commit_pulse out  1     high 1 cycle after the last slot of a commit is written
//   frame_count  out  16    number of completed commits, wraps 0xFFFF->0
//   bad_id       out  1     sticky; set when a request with req_id >= NUM_SPRITES is accepted
// BEHAVIOUR
//   Reset (iRST_n=0 at posedge): all shadow/live positions 0, pending bits 0, FSM=IDLE,
//     req_ready=0 during reset, commit_pulse=0, frame_count=0, bad_id=0, vs_d=1.
//   Handshake: transfer when req_valid & req_ready at posedge. req_ready=1 in IDLE only.
//     Requester holds req_* stable while valid & !ready.
//   Accepted request: x_c = min(req_x, X_MAX-SPRITE_W); y_c = min(req_y, Y_MAX-SPRITE_W),
//     compare on full 32 bits, then truncate to 10/9 bits. Writes shadow[req_id], sets pending.
//     Repeat writes to the same slot before a commit: last accepted value wins.
//     req_id >= NUM_SPRITES: accepted (ready honoured), no slot changes, bad_id<=1.
//   vsync edge: vs_d registers iVS each cycle; vs_fall = vs_d & ~iVS.
//   FSM states:
//     IDLE   : on vs_fall -> COMMIT with slot index k=0; else stay.
//     COMMIT : one slot per cycle: if pending[k], live[k]<=shadow[k], pending[k]<=0.
//              k==NUM_SPRITES-1 -> DONE, else k<=k+1. req_ready=0 throughout.
//     DONE   : commit_pulse<=1 for this cycle only, frame_count<=frame_count+1 -> IDLE.
//   Latency: request accepted in frame N appears on live outputs at cycle vs_fall+1+k
//     (k = slot index); all slots stable by commit_pulse. Non-pending slots keep old values.
//   vs_fall while in COMMIT/DONE: ignored (cannot occur at real frame rates; no queueing).
//   Request coincident with vs_fall in IDLE: accepted, written to shadow that same edge,
//     and the commit reads the updated shadow (commit starts next cycle).
//   Reset asserted mid-COMMIT: everything returns to reset values; partial commit discarded.
//   Outputs are registered; no combinational path from req_* to sprite_x/sprite_y.
// TESTING
//   1. Reset, then req id0 x=100 y=50 in active video -> sprite_x[9:0] stays 0 until vs_fall;
//      =100, y=50 at vs_fall+1; commit_pulse at vs_fall+4; frame_count=1.
//   2. req id1 x=700 y=470 -> after commit sprite_x slot1=608, sprite_y slot1=448 (clamped).
//   3. Two reqs to id2 (x=10 then x=20) within one frame -> committed x=20; slot0/1 unchanged.
//   4. Hold req_valid across vs_fall -> req_ready=0 for 4 cycles (COMMIT x3 + DONE), transfer
//      completes on first IDLE cycle; value lands in next frame's commit.
//   5. req id3 -> bad_id=1 and stays 1, no live output changes at next commit.
//   6. Assert iRST_n=0 during COMMIT at k=1 -> all outputs 0 next cycle, frame_count=0.

Source files
------------

// File: rtl/vga_sprite_update_scheduler.sv
// Frame-synchronous sprite position scheduler.
// Game logic posts sprite position updates through a valid/ready port at any time.
// Each update is clamped and staged in a shadow register. The staged values are copied
// to the live outputs one slot per cycle, starting at the falling edge of vsync, so the
// overlay never sees a position change in the middle of a frame.
// Ports:
//   iVGA_CLK     pixel clock (posedge)
//   iRST_n       synchronous active-low reset
//   iVS          active-low vsync
//   req_valid/req_ready/req_id/req_x/req_y   update request handshake
//   sprite_x/sprite_y   live positions, slot i at [10*i +: 10] / [9*i +: 9]
//   commit_pulse one-cycle strobe after the last slot of a commit is written
//   frame_count  completed commit counter (wraps)
//   bad_id       sticky flag for accepted requests that target a nonexistent slot
module vga_sprite_update_scheduler #(
  parameter int unsigned NUM_SPRITES = 3,
  parameter int unsigned X_MAX       = 640,
  parameter int unsigned Y_MAX       = 480,
  parameter int unsigned SPRITE_W    = 32
) (
  input  logic                        iVGA_CLK,
  input  logic                        iRST_n,
  input  logic                        iVS,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [1:0]                  req_id,
  input  logic [31:0]                 req_x,
  input  logic [31:0]                 req_y,
  output logic [10*NUM_SPRITES-1:0]   sprite_x,
  output logic [9*NUM_SPRITES-1:0]    sprite_y,
  output logic                        commit_pulse,
  output logic [15:0]                 frame_count,
  output logic                        bad_id
);

  localparam int unsigned XW     = 10;
  localparam int unsigned YW     = 9;
  localparam int unsigned KW     = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int unsigned X_LIM  = X_MAX - SPRITE_W;
  localparam int unsigned Y_LIM  = Y_MAX - SPRITE_W;
  localparam int unsigned K_LAST = NUM_SPRITES - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                  state;
  logic [KW-1:0]           k;
  logic                    vs_d;
  logic [NUM_SPRITES-1:0]  pending;
  logic [XW-1:0]           shadow_x [NUM_SPRITES];
  logic [YW-1:0]           shadow_y [NUM_SPRITES];
  logic [XW-1:0]           live_x   [NUM_SPRITES];
  logic [YW-1:0]           live_y   [NUM_SPRITES];

  logic                    vs_fall;
  logic                    accept;
  logic                    id_ok;
  logic [XW-1:0]           x_clamp;
  logic [YW-1:0]           y_clamp;

  // Request decode: clamp on the full 32-bit value so large requests saturate instead of wrapping.
  always_comb begin
    vs_fall = vs_d & ~iVS;
    accept  = req_valid & req_ready;
    id_ok   = 32'(req_id) < NUM_SPRITES;
    x_clamp = (req_x > X_LIM) ? XW'(X_LIM) : req_x[XW-1:0];
    y_clamp = (req_y > Y_LIM) ? YW'(Y_LIM) : req_y[YW-1:0];
  end

  // Shadow staging, vsync edge detect and the commit sequencer.
  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      state        <= IDLE;
      k            <= '0;
      vs_d         <= 1'b1;
      pending      <= '0;
      req_ready    <= 1'b0;
      commit_pulse <= 1'b0;
      frame_count  <= '0;
      bad_id       <= 1'b0;
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
        shadow_x[i] <= '0;
        shadow_y[i] <= '0;
        live_x[i]   <= '0;
        live_y[i]   <= '0;
      end
    end else begin
      vs_d         <= iVS;
      commit_pulse <= 1'b0;

      // Requests are only accepted in IDLE, so this never races the commit below.
      if (accept) begin
        if (id_ok) begin
          shadow_x[req_id] <= x_clamp;
          shadow_y[req_id] <= y_clamp;
          pending[req_id]  <= 1'b1;
        end else begin
          bad_id <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (vs_fall) begin
            state     <= COMMIT;
            k         <= '0;
            req_ready <= 1'b0;
          end else begin
            req_ready <= 1'b1;
          end
        end
        COMMIT: begin
          if (pending[k]) begin
            live_x[k]  <= shadow_x[k];
            live_y[k]  <= shadow_y[k];
            pending[k] <= 1'b0;
          end
          if (k == KW'(K_LAST)) begin
            state <= DONE;
          end else begin
            k <= k + KW'(1);
          end
        end
        DONE: begin
          commit_pulse <= 1'b1;
          frame_count  <= frame_count + 16'd1;
          state        <= IDLE;
          req_ready    <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

  // Flatten the live registers onto the packed output buses.
  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_pack
    assign sprite_x[XW*g +: XW] = live_x[g];
    assign sprite_y[YW*g +: YW] = live_y[g];
  end

endmodule

// File: tb/tb_vga_sprite_update_scheduler.sv
// Self-checking bench for vga_sprite_update_scheduler.
// A reference model of shadow/pending/live state predicts each commit; the prediction is
// queued when vsync falls and checked by a monitor whenever commit_pulse is seen.
module tb_vga_sprite_update_scheduler;

  localparam int unsigned NS    = 3;
  localparam int unsigned X_LIM = 640 - 32;
  localparam int unsigned Y_LIM = 480 - 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vs;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_id;
  logic [31:0] req_x;
  logic [31:0] req_y;
  logic [29:0] sprite_x;
  logic [26:0] sprite_y;
  logic        commit_pulse;
  logic [15:0] frame_count;
  logic        bad_id;

  int vectors     = 0;
  int miscompares = 0;

  vga_sprite_update_scheduler dut (
    .iVGA_CLK     (clk),
    .iRST_n       (rst_n),
    .iVS          (vs),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_id       (req_id),
    .req_x        (req_x),
    .req_y        (req_y),
    .sprite_x     (sprite_x),
    .sprite_y     (sprite_y),
    .commit_pulse (commit_pulse),
    .frame_count  (frame_count),
    .bad_id       (bad_id)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [29:0] x;
    logic [26:0] y;
    logic [15:0] fc;
    logic        bad;
  } snap_t;

  int unsigned m_sx [NS];
  int unsigned m_sy [NS];
  int unsigned m_lx [NS];
  int unsigned m_ly [NS];
  bit          m_pend [NS];
  int unsigned m_fc;
  bit          m_bad;
  snap_t       sb_q [$];
  snap_t       mon_e;

  function automatic int unsigned clampv(input int unsigned v, input int unsigned lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NS; i++) begin
      m_sx[i] = 0; m_sy[i] = 0; m_lx[i] = 0; m_ly[i] = 0; m_pend[i] = 0;
    end
    m_fc  = 0;
    m_bad = 0;
    sb_q.delete();
  endfunction

  function automatic void model_accept(input int unsigned id, input int unsigned x, input int unsigned y);
    if (id < NS) begin
      m_sx[id]   = clampv(x, X_LIM);
      m_sy[id]   = clampv(y, Y_LIM);
      m_pend[id] = 1;
    end else begin
      m_bad = 1;
    end
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s = '0;
    for (int i = 0; i < NS; i++) begin
      s.x[10*i +: 10] = 10'(m_lx[i]);
      s.y[9*i +: 9]   = 9'(m_ly[i]);
    end
    s.fc  = 16'(m_fc);
    s.bad = m_bad;
    return s;
  endfunction

  // Whole-frame commit: every pending slot takes its staged value.
  function automatic void model_commit();
    for (int i = 0; i < NS; i++) begin
      if (m_pend[i]) begin
        m_lx[i]   = m_sx[i];
        m_ly[i]   = m_sy[i];
        m_pend[i] = 0;
      end
    end
    m_fc = (m_fc + 1) % 65536;
    sb_q.push_back(model_snap());
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every commit_pulse must match the oldest predicted commit.
  always @(negedge clk) begin
    if (commit_pulse === 1'b1) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_commit_pulse: got pulse want none at %0t", $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk("commit_sprite_x", 32'(sprite_x), 32'(mon_e.x));
        chk("commit_sprite_y", 32'(sprite_y), 32'(mon_e.y));
        chk("commit_frame_count", 32'(frame_count), 32'(mon_e.fc));
        chk("commit_bad_id", 32'(bad_id), 32'(mon_e.bad));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send(input logic [1:0] id, input logic [31:0] x, input logic [31:0] y);
    bit rdy;
    int n;
    n = 0;
    req_valid = 1'b1; req_id = id; req_x = x; req_y = y;
    do begin
      rdy = req_ready;
      @(negedge clk);
      n++;
    end while (!rdy && n < 40);
    req_valid = 1'b0;
    if (rdy) model_accept(id, x, y);
    else begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: got ready=0 want ready=1 within 40 cycles at %0t", $time);
    end
  endtask

  // Drop vsync while idle; optional request coincident with the falling edge (co) and/or a
  // request raised right after it and held until it is accepted (hold).
  task automatic vsync(input bit co, input bit hold, input logic [1:0] id,
                       input logic [31:0] x, input logic [31:0] y);
    bit rdy;
    vs = 1'b0;
    if (co) begin
      req_valid = 1'b1; req_id = id; req_x = x; req_y = y;
    end
    rdy = req_ready;
    @(negedge clk);
    if (co) begin
      chk("coincident_ready", 32'(rdy), 32'd1);
      if (rdy) model_accept(id, x, y);
    end
    req_valid = 1'b0;
    model_commit();
    if (hold) begin
      req_valid = 1'b1; req_id = id; req_x = x; req_y = y;
    end
    for (int c = 0; c < 4; c++) begin
      chk("ready_low_in_commit", 32'(req_ready), 32'd0);
      chk("pulse_not_early", 32'(commit_pulse), 32'd0);
      if (c >= 1) begin
        chk("slot_latency_x", 32'(sprite_x[10*(c-1) +: 10]), m_lx[c-1]);
        chk("slot_latency_y", 32'(sprite_y[9*(c-1) +: 9]), m_ly[c-1]);
      end
      if (c == 1) vs = 1'b1;
      @(negedge clk);
    end
    chk("pulse_at_done", 32'(commit_pulse), 32'd1);
    chk("ready_after_done", 32'(req_ready), 32'd1);
    @(negedge clk);
    if (hold) begin
      model_accept(id, x, y);
      req_valid = 1'b0;
    end
    chk("pulse_one_cycle", 32'(commit_pulse), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rx, ry;
    rst_n = 1'b0; vs = 1'b1; req_valid = 1'b0; req_id = '0; req_x = '0; req_y = '0;
    model_reset();
    step(3);
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_sprite_x", 32'(sprite_x), 32'd0);
    chk("reset_sprite_y", 32'(sprite_y), 32'd0);
    chk("reset_pulse", 32'(commit_pulse), 32'd0);
    chk("reset_frame_count", 32'(frame_count), 32'd0);
    chk("reset_bad_id", 32'(bad_id), 32'd0);
    rst_n = 1'b1;
    step(2);

    // Staged update is invisible until vsync, then committed.
    send(2'd0, 32'd100, 32'd50);
    step(5);
    chk("t1_x_before_vsync", 32'(sprite_x[9:0]), 32'd0);
    vsync(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    chk("t1_x", 32'(sprite_x[9:0]), 32'd100);
    chk("t1_y", 32'(sprite_y[8:0]), 32'd50);
    chk("t1_frame_count", 32'(frame_count), 32'd1);

    // Clamping.
    send(2'd1, 32'd700, 32'd470);
    step(2);
    vsync(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    chk("t2_x_clamped", 32'(sprite_x[19:10]), 32'd608);
    chk("t2_y_clamped", 32'(sprite_y[17:9]), 32'd448);

    // Last write wins.
    send(2'd2, 32'd10, 32'd5);
    send(2'd2, 32'd20, 32'd6);
    step(1);
    vsync(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    chk("t3_x_last_wins", 32'(sprite_x[29:20]), 32'd20);
    chk("t3_slot0_unchanged", 32'(sprite_x[9:0]), 32'd100);

    // Request held across the commit lands in the following frame.
    vsync(1'b0, 1'b1, 2'd1, 32'd300, 32'd200);
    chk("t4_not_yet", 32'(sprite_x[19:10]), 32'd608);
    step(2);
    vsync(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    chk("t4_landed", 32'(sprite_x[19:10]), 32'd300);

    // Out-of-range slot id.
    send(2'd3, 32'd5, 32'd5);
    chk("t5_bad_id_set", 32'(bad_id), 32'd1);
    vsync(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    chk("t5_bad_id_sticky", 32'(bad_id), 32'd1);

    // Coincident request is included in the same commit.
    vsync(1'b1, 1'b0, 2'd0, 32'd33, 32'd44);
    chk("coincident_x", 32'(sprite_x[9:0]), 32'd33);

    // Randomized frames.
    for (int f = 0; f < 14; f++) begin
      int nreq;
      nreq = int'($urandom_range(0, 4));
      for (int r = 0; r < nreq; r++) begin
        rx = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 700);
        ry = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 520);
        send(2'($urandom_range(0, 3)), rx, ry);
        step(int'($urandom_range(0, 3)));
      end
      rx = $urandom_range(0, 1000);
      ry = $urandom_range(0, 1000);
      vsync(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), rx, ry);
      step(int'($urandom_range(1, 4)));
    end

    // Reset in the middle of a commit.
    send(2'd0, 32'd123, 32'd45);
    send(2'd1, 32'd7, 32'd8);
    vs = 1'b0;
    step(2);
    chk("t6_slot0_before_reset", 32'(sprite_x[9:0]), 32'd123);
    rst_n = 1'b0;
    step(1);
    model_reset();
    chk("t6_sprite_x", 32'(sprite_x), 32'd0);
    chk("t6_sprite_y", 32'(sprite_y), 32'd0);
    chk("t6_frame_count", 32'(frame_count), 32'd0);
    chk("t6_pulse", 32'(commit_pulse), 32'd0);
    chk("t6_ready", 32'(req_ready), 32'd0);
    chk("t6_bad_id", 32'(bad_id), 32'd0);
    vs = 1'b1;
    step(1);
    rst_n = 1'b1;
    step(3);
    vsync(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    chk("t6_after_reset_x", 32'(sprite_x), 32'd0);
    chk("t6_after_reset_fc", 32'(frame_count), 32'd1);

    step(3);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
